countdown_mod_n: RTL and testbench

//  Cascadable modulo-N down-counter (N-1 -> 0) with terminal-count and borrow outputs.

---
 rtl/countdown_mod_n_pkg.sv | 19 +
 rtl/countdown_mod_n_if.sv | 29 ++
 rtl/countdown_mod_n.sv | 72 +++++++
 tb/tb_countdown_mod_n.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/countdown_mod_n_pkg.sv
// Shared counter definitions: ceiling-log2 helper and RUN/HALT state encoding.
// Pure declarations; no latency and no flow control involved.
package countdown_mod_n_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_mod_n_if.sv
// Control/status bundle for one countdown stage; load/load_val exist only with COUNTDOWN_LOAD_EN.
// Signals only, no latency; ce is a per-cycle enable with no backpressure path.
interface countdown_mod_n_if
    import countdown_mod_n_pkg::*;
#(
    parameter int N     = 8,
    parameter int WIDTH = clog2(N) - 1
) ();

    logic             ce;
    logic             start;
    logic [WIDTH:0]   out;
    logic             tc;
    logic             borrow;
    logic             busy;
`ifdef COUNTDOWN_LOAD_EN
    logic             load;
    logic [WIDTH:0]   load_val;
`endif

`ifdef COUNTDOWN_LOAD_EN
    modport master (output ce, start, load, load_val, input out, tc, borrow, busy);
    modport slave  (input ce, start, load, load_val, output out, tc, borrow, busy);
`else
    modport master (output ce, start, input out, tc, borrow, busy);
    modport slave  (input ce, start, output out, tc, borrow, busy);
`endif

endinterface

// File: rtl/countdown_mod_n.sv
// Cascadable mod-N down-counter (N-1..0), tc/borrow for chaining; optional load via COUNTDOWN_LOAD_EN.
// Count updates one cycle after ce/start/load, tc/borrow combinational; no backpressure, ce gates stepping.
module countdown_mod_n
    import countdown_mod_n_pkg::*;
#(
    parameter int N           = 8,
    parameter int WIDTH       = clog2(N) - 1,
    parameter bit AUTO_RELOAD = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    countdown_mod_n_if.slave     io_ctr
);

    localparam logic [WIDTH:0] LP_MAX = (WIDTH + 1)'(N - 1);
    localparam logic [WIDTH:0] LP_ONE = (WIDTH + 1)'(1);

    state_e          r_state;
    logic [WIDTH:0]  r_cnt;

    state_e          w_state_nxt;
    logic [WIDTH:0]  w_cnt_nxt;
    logic            w_tc;
    logic            w_borrow;
    logic            w_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_cnt   <= LP_MAX;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tc        = (r_cnt == '0);
        w_busy      = (r_state == ST_RUN);
        w_borrow    = io_ctr.ce & w_tc & w_busy;

`ifdef COUNTDOWN_LOAD_EN
        if (io_ctr.load) begin
            // Out-of-range load values saturate so the count never leaves 0..N-1.
            w_cnt_nxt   = (io_ctr.load_val > LP_MAX) ? LP_MAX : io_ctr.load_val;
            w_state_nxt = ST_RUN;
        end else
`endif
        if (!AUTO_RELOAD && io_ctr.start) begin
            w_cnt_nxt   = LP_MAX;
            w_state_nxt = ST_RUN;
        end else if (io_ctr.ce && (r_state == ST_RUN)) begin
            if (w_tc) begin
                if (AUTO_RELOAD) begin
                    w_cnt_nxt = LP_MAX;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end else begin
                w_cnt_nxt = r_cnt - LP_ONE;
            end
        end
    end

    assign io_ctr.out    = r_cnt;
    assign io_ctr.tc     = w_tc;
    assign io_ctr.borrow = w_borrow;
    assign io_ctr.busy   = w_busy;

endmodule

// File: tb/tb_countdown_mod_n.sv
// Directed checks of countdown_mod_n: free-running, one-shot, reset, load and a two-stage chain.
// Stimulus queues expected outputs per cycle; a negedge monitor drains the queue and compares.
module tb_countdown_mod_n;
    import countdown_mod_n_pkg::*;

    localparam int ID8 = 0;
    localparam int ID5 = 1;
    localparam int ID4 = 2;
    localparam int IDA = 3;
    localparam int IDB = 4;

    typedef struct {
        int    id;
        string nm;
        int    out;
        bit    tc;
        bit    borrow;
        bit    busy;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8, rst5, rst4, rstc;

    countdown_mod_n_if #(.N(8))  if8 ();
    countdown_mod_n_if #(.N(5))  if5 ();
    countdown_mod_n_if #(.N(4))  if4 ();
    countdown_mod_n_if #(.N(10)) ifa ();
    countdown_mod_n_if #(.N(10)) ifb ();

    countdown_mod_n #(.N(8),  .AUTO_RELOAD(1'b1)) u8 (.i_clk(clk), .i_rst(rst8), .io_ctr(if8));
    countdown_mod_n #(.N(5),  .AUTO_RELOAD(1'b1)) u5 (.i_clk(clk), .i_rst(rst5), .io_ctr(if5));
    countdown_mod_n #(.N(4),  .AUTO_RELOAD(1'b0)) u4 (.i_clk(clk), .i_rst(rst4), .io_ctr(if4));
    countdown_mod_n #(.N(10), .AUTO_RELOAD(1'b1)) ua (.i_clk(clk), .i_rst(rstc), .io_ctr(ifa));
    countdown_mod_n #(.N(10), .AUTO_RELOAD(1'b1)) ub (.i_clk(clk), .i_rst(rstc), .io_ctr(ifb));

    // Second decade steps only when the first stage borrows.
    assign ifb.ce = ifa.borrow;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input string nm, input int o, input bit b, input bit bz);
        exp_t e;
        e.id     = id;
        e.nm     = nm;
        e.out    = o;
        e.tc     = (o == 0);
        e.borrow = b;
        e.busy   = bz;
        sb.push_back(e);
    endtask

    task automatic get_act(input int id, output int o, output bit t, output bit b, output bit bz);
        case (id)
            ID8:     begin o = int'(if8.out); t = if8.tc; b = if8.borrow; bz = if8.busy; end
            ID5:     begin o = int'(if5.out); t = if5.tc; b = if5.borrow; bz = if5.busy; end
            ID4:     begin o = int'(if4.out); t = if4.tc; b = if4.borrow; bz = if4.busy; end
            IDA:     begin o = int'(ifa.out); t = ifa.tc; b = ifa.borrow; bz = ifa.busy; end
            default: begin o = int'(ifb.out); t = ifb.tc; b = ifb.borrow; bz = ifb.busy; end
        endcase
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   o;
        bit   t, b, bz;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_act(e.id, o, t, b, bz);
            n_tests++;
            if (o != e.out || t != e.tc || b != e.borrow || bz != e.busy) begin
                n_fail++;
                $display("FAIL %s dut%0d: got out=%0d tc=%0d borrow=%0d busy=%0d, want out=%0d tc=%0d borrow=%0d busy=%0d",
                         e.nm, e.id, o, t, b, bz, e.out, e.tc, e.borrow, e.busy);
            end
        end
    end

    initial begin
        int d;
        int v;
        rst8 = 1'b1; rst5 = 1'b1; rst4 = 1'b1; rstc = 1'b1;
        if8.ce = 1'b0; if8.start = 1'b0;
        if5.ce = 1'b0; if5.start = 1'b0;
        if4.ce = 1'b0; if4.start = 1'b0;
        ifa.ce = 1'b0; ifa.start = 1'b0;
        ifb.start = 1'b0;
`ifdef COUNTDOWN_LOAD_EN
        if8.load = 1'b0; if8.load_val = '0;
        if5.load = 1'b0; if5.load_val = '0;
        if4.load = 1'b0; if4.load_val = '0;
        ifa.load = 1'b0; ifa.load_val = '0;
        ifb.load = 1'b0; ifb.load_val = '0;
`endif

        // Reset state of every instance
        tick();
        rst8 = 1'b0; rst5 = 1'b0; rst4 = 1'b0; rstc = 1'b0;
        push(ID8, "rst8", 7, 1'b0, 1'b1);
        push(ID5, "rst5", 4, 1'b0, 1'b1);
        push(ID4, "rst4", 3, 1'b0, 1'b1);
        push(IDA, "rsta", 9, 1'b0, 1'b1);
        push(IDB, "rstb", 9, 1'b0, 1'b1);

        // N=8 free-running: 7..0,7.. with borrow on the zero cycle
        for (int k = 0; k < 17; k++) begin
            tick();
            if8.ce = 1'b1;
            push(ID8, "wrap8", 7 - (k % 8), (k % 8) == 7, 1'b1);
        end
        tick();
        if8.ce = 1'b0;
        push(ID8, "hold8", 6, 1'b0, 1'b1);

        // start has no effect with auto-reload
        tick();
        if8.ce = 1'b1; if8.start = 1'b1;
        push(ID8, "start_ar", 6, 1'b0, 1'b1);
        tick();
        if8.ce = 1'b0; if8.start = 1'b0;
        push(ID8, "start_ar_nxt", 5, 1'b0, 1'b1);

        // Reset mid-count with ce high
        tick(); if8.ce = 1'b1; push(ID8, "pre_rst", 5, 1'b0, 1'b1);
        tick(); if8.ce = 1'b1; push(ID8, "pre_rst", 4, 1'b0, 1'b1);
        tick(); if8.ce = 1'b1; rst8 = 1'b1; push(ID8, "rst_mid", 3, 1'b0, 1'b1);
        tick(); if8.ce = 1'b0; rst8 = 1'b0; push(ID8, "rst_mid_nxt", 7, 1'b0, 1'b1);

        // N=5 with ce toggling
        for (int k = 0; k < 12; k++) begin
            tick();
            if5.ce = (k % 2 == 0);
            d = (k + 1) / 2;
            v = (4 - (d % 5) + 5) % 5;
            push(ID5, "toggle5", v, (k % 2 == 0) && (v == 0), 1'b1);
        end
        tick();
        if5.ce = 1'b0;
        push(ID5, "toggle5_end", 3, 1'b0, 1'b1);

        // One-shot N=4: count down, halt, then start and retrigger
        for (int k = 0; k < 4; k++) begin
            tick();
            if4.ce = 1'b1;
            push(ID4, "os_run", 3 - k, k == 3, 1'b1);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if4.ce = 1'b1;
            push(ID4, "os_halt", 0, 1'b0, 1'b0);
        end
        tick(); if4.ce = 1'b1; if4.start = 1'b1; push(ID4, "os_start", 0, 1'b0, 1'b0);
        tick(); if4.ce = 1'b1; if4.start = 1'b0; push(ID4, "os_rearm", 3, 1'b0, 1'b1);
        tick(); if4.ce = 1'b1; if4.start = 1'b1; push(ID4, "os_retrig", 2, 1'b0, 1'b1);
        tick(); if4.ce = 1'b0; if4.start = 1'b0; push(ID4, "os_retrig_nxt", 3, 1'b0, 1'b1);

`ifdef COUNTDOWN_LOAD_EN
        // Load beats start and ce; load of 0 borrows on the next ce
        tick();
        if8.load = 1'b1; if8.load_val = 3'd2; if8.start = 1'b1; if8.ce = 1'b1;
        push(ID8, "ld_pri", 7, 1'b0, 1'b1);
        tick(); if8.load = 1'b0; if8.start = 1'b0; if8.ce = 1'b1; push(ID8, "ld2", 2, 1'b0, 1'b1);
        tick(); if8.ce = 1'b1; push(ID8, "ld2_dec", 1, 1'b0, 1'b1);
        tick(); if8.ce = 1'b1; push(ID8, "ld2_zero", 0, 1'b1, 1'b1);
        tick(); if8.ce = 1'b0; push(ID8, "ld2_wrap", 7, 1'b0, 1'b1);
        tick(); if8.load = 1'b1; if8.load_val = 3'd0; push(ID8, "ld0_pre", 7, 1'b0, 1'b1);
        tick(); if8.load = 1'b0; if8.ce = 1'b1; push(ID8, "ld0_borrow", 0, 1'b1, 1'b1);
        tick(); if8.ce = 1'b0; push(ID8, "ld0_wrap", 7, 1'b0, 1'b1);
        // Saturation on a non-power-of-2 modulus
        tick(); if5.load = 1'b1; if5.load_val = 3'd7; push(ID5, "ld_sat_pre", 3, 1'b0, 1'b1);
        tick(); if5.load = 1'b0; push(ID5, "ld_sat", 4, 1'b0, 1'b1);
`endif

        // Two N=10 stages chained: combined 99..00 wraps
        for (int k = 0; k < 205; k++) begin
            tick();
            ifa.ce = 1'b1;
            v = 99 - (k % 100);
            push(IDA, "chain_lo", v % 10, (v % 10) == 0, 1'b1);
            push(IDB, "chain_hi", v / 10, v == 0, 1'b1);
        end
        tick();
        ifa.ce = 1'b0;
        push(IDA, "chain_lo_end", 4, 1'b0, 1'b1);
        push(IDB, "chain_hi_end", 9, 1'b0, 1'b1);

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
